fifo_wptr_full_m_r: RTL and testbench
=====================================

// Module: fifo_wptr_full_m_r
// PURPOSE
//  Write-side pointer/full controller for the M->R (master read-data) async FIFO; upstream of
//  the dual-port FIFO memory. Converts producer pushes into a binary write address and a Gray
//  write pointer. Brings the read-domain Gray pointer into wclk through a 2-flop synchroniser.
//  Generates a registered, conservative full flag that gates memory writes.
// PARAMETERS
//  ADDRSIZE   4  FIFO address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits
//  AF_MARGIN  2  almost-full threshold margin (used only with FIFO_ALMOST_FULL_EN)
// PORTS
//  wclk          in   1           write-domain clock; all logic on posedge
//  wrst_n        in   1           reset, synchronous, active-low
//  wpush         in   1           producer push request (write-domain)
//  rptr          in   ADDRSIZE+1  read Gray pointer from read domain (asynchronous to wclk)
//  waddr         out  ADDRSIZE    binary write address to FIFO memory
//  wptr          out  ADDRSIZE+1  registered Gray write pointer, to read-domain synchroniser
//  wfull         out  1           FIFO full; memory and this block ignore wpush while high
//  woverflow     out  1           sticky: a push was attempted while wfull=1
//  walmost_full  out  1           only with FIFO_ALMOST_FULL_EN
// BEHAVIOUR
//  - Reset (wrst_n=0 at a wclk edge, overrides wpush): wbin=0, wptr=0, wq1_rptr=wq2_rptr=0,
//    wfull=0, woverflow=0, walmost_full=0.
//  - Synchroniser: wq1_rptr<=rptr; wq2_rptr<=wq1_rptr. Only wq2_rptr feeds logic.
//  - Push accepted = wpush & ~wfull. wbinnext = wbin + accepted, modulo 2**(ADDRSIZE+1).
//    wgraynext = (wbinnext>>1) ^ wbinnext.
//  - Registers: wbin<=wbinnext; wptr<=wgraynext.
//  - waddr = wbin[ADDRSIZE-1:0]: combinational from the register, zero extra latency.
//  - The memory writes at waddr on the same edge the push is accepted.
//  - wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
//    wfull rises on the same edge that accepts the push filling the last slot.
//  - wfull falls no earlier than the 3rd wclk edge after rptr changes (2 sync + 1 register).
//    This delay is conservative by design and never causes overflow.
//  - Push while full: wbin and wptr hold; woverflow <= 1 and stays set until reset.
//  - Simultaneous push and read-pointer advance: the push is judged against the current
//    wfull register; the freed slot is seen only after synchronisation.
//  - Wrap-around: the MSB toggles every 2**ADDRSIZE pushes. The Gray code changes exactly one
//    bit per accepted push, including the wrap from all-ones to 0.
//  - Reset mid-burst: all state clears at the reset edge. In-flight pushes are lost. The read
//    side is reset by the system in the same window.
// CONFIGURATION
//  FIFO_ALMOST_FULL_EN defined:
//    - rbin_s = gray2bin(wq2_rptr); wcount = wbinnext - rbin_s, ADDRSIZE+1 bits, modulo.
//    - walmost_full <= (wcount >= 2**ADDRSIZE - AF_MARGIN); reset value 0.
//  FIFO_ALMOST_FULL_EN undefined: walmost_full tied 0; no gray2bin or subtractor logic.
// TESTING  (ADDRSIZE=2, depth 4, rptr held at 3'b000 unless stated)
//  1 wrst_n=0 for 2 edges with wpush=1 -> waddr=0, wptr=000, wfull=0, woverflow=0.
//  2 4 consecutive pushes -> waddr 0,1,2,3 then 0.
//    After the 4th edge: wptr=3'b110 (bin 100), wfull=1.
//  3 5th push while full -> waddr stays 0, wptr stays 110, woverflow=1 from that edge on.
//  4 From test 3, rptr set to 3'b001 -> wfull=1 after edges 1 and 2, wfull=0 after edge 3.
//  5 8 pushes with rptr tracking 2 entries behind -> wbin wraps 111->000.
//    Observe wptr 100->000 and waddr 3->0; wfull never set.
//  6 FIFO_ALMOST_FULL_EN, AF_MARGIN=1: 3 pushes -> walmost_full=1 after the 3rd edge, wfull=0.
//    Then rptr=001 -> walmost_full=0 after the 3rd edge.

Source files
------------

// File: rtl/fifo_wptr_full_m_r.sv
// Write-side pointer and full-flag controller for the M->R async FIFO.
// Optional almost-full flag is built only when FIFO_ALMOST_FULL_EN is defined.
module fifo_wptr_full_m_r #(
    parameter int ADDRSIZE  = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                wpush,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                woverflow,
    output logic                walmost_full
);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] wq1_rptr;
    logic [ADDRSIZE:0] wq2_rptr;
    logic [ADDRSIZE:0] full_target;
    logic              accepted;

    assign accepted    = wpush & ~wfull;
    assign wbinnext    = wbin + {{ADDRSIZE{1'b0}}, accepted};
    assign wgraynext   = (wbinnext >> 1) ^ wbinnext;
    assign waddr       = wbin[ADDRSIZE-1:0];
    // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
    assign full_target = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr      <= '0;
            wq1_rptr  <= '0;
            wq2_rptr  <= '0;
            wfull     <= 1'b0;
            woverflow <= 1'b0;
        end else begin
            wbin     <= wbinnext;
            wptr     <= wgraynext;
            wq1_rptr <= rptr;
            wq2_rptr <= wq1_rptr;
            wfull    <= (wgraynext == full_target);
            if (wpush && wfull) begin
                woverflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [ADDRSIZE:0] AF_LEVEL = (ADDRSIZE+1)'((2 ** ADDRSIZE) - AF_MARGIN);

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] wcount;
    logic              af_q;

    assign rbin_s       = gray2bin(wq2_rptr);
    assign wcount       = wbinnext - rbin_s;
    assign walmost_full = af_q;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            af_q <= 1'b0;
        end else begin
            af_q <= (wcount >= AF_LEVEL);
        end
    end
`else
    logic unused_af_margin;
    assign unused_af_margin = (AF_MARGIN == 0);
    assign walmost_full     = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full_m_r.sv
// Directed bench for fifo_wptr_full_m_r at ADDRSIZE=2 (depth 4), AF_MARGIN=1.
module tb_fifo_wptr_full_m_r;

    logic       wclk;
    logic       wrst_n;
    logic       wpush;
    logic [2:0] rptr;
    logic [1:0] waddr;
    logic [2:0] wptr;
    logic       wfull;
    logic       woverflow;
    logic       walmost_full;

    int n_checks = 0;
    int n_fails  = 0;

    fifo_wptr_full_m_r #(.ADDRSIZE(2), .AF_MARGIN(1)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .wpush        (wpush),
        .rptr         (rptr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .woverflow    (woverflow),
        .walmost_full (walmost_full)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Gray codes of binary 1..8 (mod 8), hand-written.
    logic [2:0] gray_exp [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                                 3'b111, 3'b101, 3'b100, 3'b000};
    // Read side keeps up with every write: rptr is the Gray code of the write count.
    logic [2:0] rd_gray  [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                 3'b111, 3'b101, 3'b100, 3'b000};

    initial begin
        wrst_n = 1'b0;
        wpush  = 1'b1;
        rptr   = 3'b000;

        // Reset held for two edges overrides an active push.
        step();
        step();
        check("rst_waddr",    8'(waddr),        8'd0);
        check("rst_wptr",     8'(wptr),         8'd0);
        check("rst_wfull",    8'(wfull),        8'd0);
        check("rst_overflow", 8'(woverflow),    8'd0);
        check("rst_af",       8'(walmost_full), 8'd0);

        // Four pushes fill the FIFO.
        wrst_n = 1'b1;
        step();
        check("fill1_waddr", 8'(waddr), 8'd1);
        check("fill1_wptr",  8'(wptr),  8'b001);
        check("fill1_wfull", 8'(wfull), 8'd0);
        step();
        check("fill2_waddr", 8'(waddr), 8'd2);
        check("fill2_wptr",  8'(wptr),  8'b011);
        step();
        check("fill3_waddr", 8'(waddr), 8'd3);
        check("fill3_wptr",  8'(wptr),  8'b010);
        check("fill3_wfull", 8'(wfull), 8'd0);
`ifdef FIFO_ALMOST_FULL_EN
        check("fill3_af",    8'(walmost_full), 8'd1);
`else
        check("fill3_af",    8'(walmost_full), 8'd0);
`endif
        step();
        check("fill4_waddr", 8'(waddr),     8'd0);
        check("fill4_wptr",  8'(wptr),      8'b110);
        check("fill4_wfull", 8'(wfull),     8'd1);
        check("fill4_ovf",   8'(woverflow), 8'd0);

        // Push while full is dropped and sets the sticky overflow.
        step();
        check("ovf_waddr", 8'(waddr),     8'd0);
        check("ovf_wptr",  8'(wptr),      8'b110);
        check("ovf_wfull", 8'(wfull),     8'd1);
        check("ovf_flag",  8'(woverflow), 8'd1);

        // Read pointer advances by one; full clears only on the third edge.
        wpush = 1'b0;
        rptr  = 3'b001;
        step();
        check("drain1_wfull", 8'(wfull), 8'd1);
        step();
        check("drain2_wfull", 8'(wfull), 8'd1);
        step();
        check("drain3_wfull", 8'(wfull),     8'd0);
        check("drain3_wptr",  8'(wptr),      8'b110);
        check("drain3_ovf",   8'(woverflow), 8'd1);

        // Reset clears overflow, then eight pushes wrap the binary pointer.
        wrst_n = 1'b0;
        rptr   = 3'b000;
        step();
        check("rst2_ovf",  8'(woverflow), 8'd0);
        check("rst2_wptr", 8'(wptr),      8'd0);
        wrst_n = 1'b1;
        wpush  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            rptr = rd_gray[k];
            check($sformatf("wrap%0d_waddr", k), 8'(waddr), 8'(k % 4));
            check($sformatf("wrap%0d_wptr", k),  8'(wptr),  8'(gray_exp[k-1]));
            check($sformatf("wrap%0d_wfull", k), 8'(wfull), 8'd0);
        end
        check("wrap_ovf", 8'(woverflow), 8'd0);

`ifdef FIFO_ALMOST_FULL_EN
        // Almost-full rises at three entries and falls once the freed slot is synced.
        wrst_n = 1'b0;
        wpush  = 1'b0;
        rptr   = 3'b000;
        step();
        wrst_n = 1'b1;
        wpush  = 1'b1;
        step();
        step();
        check("af2", 8'(walmost_full), 8'd0);
        step();
        check("af3",       8'(walmost_full), 8'd1);
        check("af3_wfull", 8'(wfull),        8'd0);
        wpush = 1'b0;
        rptr  = 3'b001;
        step();
        check("af_drain1", 8'(walmost_full), 8'd1);
        step();
        check("af_drain2", 8'(walmost_full), 8'd1);
        step();
        check("af_drain3", 8'(walmost_full), 8'd0);
`else
        check("af_tied", 8'(walmost_full), 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
